// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// opcode encoding, FSM state encoding, default datapath width and a
// helper to classify iterative opcodes.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // True for the ops that occupy the iterative datapath.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage <-> muldiv unit bus.
//   master (EX pipeline side): drives start/op/rs_val/rt_val/mf_req/flush,
//                              observes stall/busy/done/hi/lo.
//   slave  (muldiv unit):      the reverse.
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mf_req;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, mf_req, flush,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, mf_req, flush,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-step unsigned multiply / restoring divide datapath.
//   load     : capture operand magnitudes, clear accumulator
//   step     : perform one iteration
//   div_mode : 0 = shift-add multiply, 1 = shift-subtract divide
//   a_mag    : multiplicand / dividend magnitude
//   b_mag    : multiplier / divisor magnitude
//   res_hi   : product high half / remainder
//   res_lo   : product low half / quotient
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc carries one guard bit: multiply carry-out / divide borrow.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;   // multiplier (mul) or dividend->quotient (div)
  logic [WIDTH-1:0] m_q, m_d;     // multiplicand (mul) or divisor (div)
  logic [WIDTH:0]   sum, rem_sh, diff;

  always_comb begin
    acc_d  = acc_q;
    mq_d   = mq_q;
    m_d    = m_q;
    sum    = acc_q + {1'b0, m_q};
    rem_sh = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, m_q};
    if (load) begin
      acc_d = '0;
      mq_d  = div_mode ? a_mag : b_mag;
      m_d   = div_mode ? b_mag : a_mag;
    end else if (step) begin
      if (!div_mode) begin
        // {acc,mq} >>= 1 after conditionally adding the multiplicand.
        if (mq_q[0]) begin
          acc_d = {1'b0, sum[WIDTH:1]};
          mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[WIDTH:1]};
          mq_d  = {acc_q[0], mq_q[WIDTH-1:1]};
        end
      end else begin
        // Borrow (diff MSB) means the trial subtract failed: restore.
        if (!diff[WIDTH]) begin
          acc_d = diff;
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh;
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mq_q  <= '0;
      m_q   <= '0;
    end else begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      m_q   <= m_d;
    end
  end

  assign res_hi = acc_q[WIDTH-1:0];
  assign res_lo = mq_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit owning HI/LO.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of ex_muldiv_unit_if (start/op/operands/mf_req/
//                flush in; stall/busy/done/hi/lo out)
// MULT/MULTU/DIV/DIVU take WIDTH+1 edges from acceptance to HI/LO update;
// MTHI/MTLO write in the accepting edge.
module ex_muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_muldiv_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_q, div_d;     // op is a divide
  logic             sgn_q, sgn_d;     // op is signed
  logic             neg_q, neg_d;     // operand signs differ
  logic             rsn_q, rsn_d;     // dividend was negative
  logic             dz_q, dz_d;       // divide by zero

  logic             op_div, op_sgn, accept;
  logic             core_load, core_step, core_mode;
  logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  assign op_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign op_sgn = (bus.op == OP_DIV) || (bus.op == OP_MULT);
  assign a_mag  = (op_sgn && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign b_mag  = (op_sgn && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
  assign accept = (state_q == ST_IDLE) && bus.start && !bus.flush && is_muldiv(bus.op);

  // Mode comes from the incoming op on the load edge, then from the latch.
  assign core_mode = (state_q == ST_IDLE) ? op_div : div_q;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (core_load),
    .step     (core_step),
    .div_mode (core_mode),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .res_hi   (core_hi),
    .res_lo   (core_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div_d     = div_q;
    sgn_d     = sgn_q;
    neg_d     = neg_q;
    rsn_d     = rsn_q;
    dz_d      = dz_q;
    core_load = 1'b0;
    core_step = 1'b0;

    // Sign fix-up of the unsigned core result.
    prod = {core_hi, core_lo};
    if (sgn_q && neg_q) prod = -prod;
    quo = core_lo;
    rem = core_hi;
    if (sgn_q && neg_q) quo = -quo;
    if (sgn_q && rsn_q) rem = -rem;
    // Zero divisor: core already leaves |rs| in rem; quotient is forced.
    if (dz_q) quo = '1;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (accept) begin
            core_load = 1'b1;
            div_d     = op_div;
            sgn_d     = op_sgn;
            neg_d     = bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1];
            rsn_d     = bus.rs_val[WIDTH-1];
            dz_d      = (bus.rt_val == '0);
            cnt_d     = CNT_W'(WIDTH);
            state_d   = ST_RUN;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.rs_val;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.rs_val;
          end
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          core_step = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        if (!bus.flush) begin
          if (div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      rsn_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      rsn_q   <= rsn_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy  = (state_q != ST_IDLE);
  // An MF issued alongside an accepted op must also wait for the result.
  assign bus.stall = (bus.busy && (bus.start || bus.mf_req)) || (accept && bus.mf_req);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {hi,lo} straight from arithmetic definitions.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia, ib, q, rm;
    logic [63:0] r;
    ia = a;
    ib = b;
    r = '0;
    case (op)
      OP_MULT:  r = longint'(ia) * longint'(ib);
      OP_MULTU: r = {32'b0, a} * {32'b0, b};
      OP_DIVU:  r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      OP_DIV: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else begin
          q  = ia / ib;
          rm = ia % ib;
          r  = {rm, q};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Behavioural model: an accepted op produces its result 33 edges later.
  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_res <= '0; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (bus.flush) m_busy <= 1'b0;
        else if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
        end else m_rem <= m_rem - 1;
      end else if (bus.start && !bus.flush) begin
        if (is_muldiv(bus.op)) begin
          m_res  <= ref_result(bus.op, bus.rs_val, bus.rt_val);
          m_rem  <= 33;
          m_busy <= 1'b1;
        end else if (bus.op == OP_MTHI) m_hi <= bus.rs_val;
        else if (bus.op == OP_MTLO) m_lo <= bus.rs_val;
      end
    end
  end

  logic exp_stall;
  assign exp_stall = (m_busy && (bus.start || bus.mf_req)) ||
                     (!m_busy && bus.start && !bus.flush && is_muldiv(bus.op) && bus.mf_req);

  always @(negedge clk) begin
    chk("busy",  64'(bus.busy),  64'(m_busy));
    chk("stall", 64'(bus.stall), 64'(exp_stall));
    chk("done",  64'(bus.done),  64'(m_done));
    chk("hi",    64'(bus.hi),    64'(m_hi));
    chk("lo",    64'(bus.lo),    64'(m_lo));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Returns the number of busy cycles observed; ends in the done cycle.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 80) begin
      n++;
      tick();
    end
    if (bus.busy) chk("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(op, a, b);
    wait_idle(n);
    chk({name, "_len"},  64'(n), 64'd33);
    chk({name, "_done"}, 64'(bus.done), 64'd1);
    chk({name, "_hi"},   64'(bus.hi), 64'(ehi));
    chk({name, "_lo"},   64'(bus.lo), 64'(elo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 0; bus.op = OP_NOP; bus.rs_val = 0; bus.rt_val = 0; bus.mf_req = 0; bus.flush = 0;
    #1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Pin the model against hand-computed values.
    chk("ref_mult", ref_result(OP_MULT, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
    chk("ref_multu", ref_result(OP_MULTU, 32'hFFFFFFFD, 32'd7), 64'h00000006_FFFFFFEB);
    chk("ref_div", ref_result(OP_DIV, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("ref_divu0", ref_result(OP_DIVU, 32'h1234, 32'd0), 64'h00001234_FFFFFFFF);

    run_check("mult",  OP_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_check("multu", OP_MULTU, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB);
    run_check("div",   OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_check("ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_check("divz",  OP_DIVU,  32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
    run_check("sdivz", OP_DIV,   32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);

    // MF waits on an in-flight MULT.
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (4) tick();
    bus.mf_req = 1'b1;
    @(negedge clk);
    chk("mf_stall", 64'(bus.stall), 64'd1);
    tick();
    wait_idle(n);
    chk("mf_stall_end", 64'(bus.stall), 64'd0);
    chk("mf_hi", 64'(bus.hi), 64'd0);
    chk("mf_lo", 64'(bus.lo), 64'd12);
    bus.mf_req = 1'b0;

    // Second start during RUN is held until IDLE.
    issue(OP_MULT, 32'd5, 32'd6);
    repeat (3) tick();
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(negedge clk);
    chk("hold_stall", 64'(bus.stall), 64'd1);
    tick();
    wait_idle(n);
    chk("hold_lo", 64'(bus.lo), 64'd30);
    tick();
    bus.start = 1'b0;
    wait_idle(n);
    chk("divu_lo", 64'(bus.lo), 64'd14);
    chk("divu_hi", 64'(bus.hi), 64'd2);

    // MTLO: single cycle, no busy, no done.
    issue(OP_MTLO, 32'h0000ABCD, 32'd0);
    chk("mtlo_lo", 64'(bus.lo), 64'h0000ABCD);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    chk("mtlo_done", 64'(bus.done), 64'd0);

    // Flush mid-RUN keeps HI/LO.
    issue(OP_MULT, 32'd9, 32'd9);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'd2);
    chk("flush_lo", 64'(bus.lo), 64'h0000ABCD);
    repeat (40) tick();

    // Reset mid DIV.
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_hi", 64'(bus.hi), 64'd0);
    chk("rstmid_lo", 64'(bus.lo), 64'd0);
    chk("rstmid_busy", 64'(bus.busy), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();

    // Randomized traffic checked by the model every cycle.
    for (int it = 0; it < 40; it++) begin
      bus.mf_req = ($urandom % 4 == 0);
      bus.flush  = ($urandom % 16 == 0);
      issue(3'($urandom_range(0, 6)), pick(), pick());
      bus.flush = 1'b0;
      for (int c = 0; c < 45 && bus.busy; c++) begin
        bus.mf_req = ($urandom % 3 == 0);
        bus.flush  = ($urandom % 60 == 0);
        bus.start  = ($urandom % 10 == 0);
        if (bus.start) begin
          bus.op = 3'($urandom_range(0, 6)); bus.rs_val = pick(); bus.rt_val = pick();
        end
        tick();
      end
      bus.start = 1'b0; bus.flush = 1'b0; bus.mf_req = 1'b0;
      tick();
      wait_idle(n);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Execute-stage iterative multiply/divide unit with the architectural HI/LO registers. It consumes operands and a muldiv opcode from the ID/EX pipeline register, and runs MULT/MULTU/DIV/DIVU at one bit per cycle. It also handles MTHI/MTLO. It drives a stall request back to the hazard logic so the front of the pipeline holds while an operation is in flight or while a MFHI/MFLO must wait.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
start  in  1  EX holds a valid muldiv-class op this cycle
op  in  3  muldiv opcode (package encoding)
rs_val  in  WIDTH  forwarded rs operand (multiplicand / dividend / MTHI/MTLO source)
rt_val  in  WIDTH  forwarded rt operand (multiplier / divisor)
mf_req  in  1  EX holds MFHI or MFLO this cycle
flush  in  1  squash the in-flight operation
stall  out  1  hold IF/ID/EX (the ID/EX register must not advance)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when HI/LO are written by mult/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (Rst=0, async): state=IDLE, hi=lo=0, counter=0, internal accumulators=0, done=0. busy and stall therefore read 0.
- States: IDLE, RUN, FINISH.
- IDLE + start + op in {MULT,MULTU,DIV,DIVU} + !flush, at edge E0:
  - latch operand magnitudes (absolute values for signed ops) and the sign flags;
  - counter=WIDTH; go to RUN.
- RUN: one shift-add (mul) or restoring shift-subtract (div) step per edge, then counter-1. When the step with counter==1 completes (edge E0+WIDTH), go to FINISH.
- FINISH, at edge E0+WIDTH+1:
  - apply sign fix-up;
  - write hi/lo; done=1 for the following cycle; go to IDLE.
- Total latency: start edge to HI/LO visible = WIDTH+1 edges (33 at default).
- Sign rules:
  - MULT: product negated if signs differ; {hi,lo} = 64-bit product.
  - DIV: lo=quotient, negated if signs differ; hi=remainder, carrying the sign of the dividend.
  - Unsigned ops: no fix-up.
- Divide by zero (rt_val=0, DIV or DIVU): runs the full latency; hi=rs_val, lo=all ones.
- Signed overflow (-2^(WIDTH-1) / -1): lo=0x80000000, hi=0.
- MTHI/MTLO in IDLE with start: hi (or lo)=rs_val at that edge. Single cycle; no done; busy stays 0.
- stall = busy & (start | mf_req). Also asserted combinationally in the cycle start is accepted only if mf_req is also set.
- start while busy: ignored (held by stall); re-presented after return to IDLE.
- mf_req in IDLE: no stall; hi/lo outputs are the registered values (the MF reads them directly).
- flush in RUN or FINISH: next edge goes to IDLE; hi/lo unchanged; no done.
- flush together with start in IDLE: start ignored.
- Reset mid-operation: immediate return to the reset state; result discarded.
- hi/lo change only on: the FINISH edge, an accepted MTHI/MTLO edge, or reset.

Decomposition:
- Package muldiv_pkg:
  - op encoding localparams: OP_NOP=0, OP_MULT=1, OP_MULTU=2, OP_DIV=3, OP_DIVU=4, OP_MTHI=5, OP_MTLO=6;
  - state encoding: IDLE=0, RUN=1, FINISH=2;
  - WIDTH default.
- One sub-module, muldiv_iter_core: the per-bit datapath (accumulator, shift registers, add/subtract step), controlled by a mode bit and a step enable. ex_muldiv_unit keeps the FSM, the sign handling, HI/LO and stall.

Test Plan:
- Reset: Rst low mid-RUN of DIV 100/7 -> hi=lo=0, busy=0 immediately; no done pulse afterwards.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> busy for 33 cycles, done one cycle, hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=0x1234, rt=0 -> after 33 cycles hi=0x1234, lo=0xFFFFFFFF, done=1.
- MULT 3*4 started, then mf_req asserted on cycle 5 -> stall=1 until the cycle after done; hi=0, lo=12. A second start during RUN -> stall=1 and the op is not accepted until IDLE.
- MTLO rs=0xABCD in IDLE -> lo=0xABCD next cycle, busy=0, no done. MULT started then flush on cycle 10 -> IDLE next cycle, hi/lo retain their prior values, done never pulses.
